// File: rtl/sprite_layer_renderer.sv
// ---------------------------------------------------------------------------
// sprite_layer_renderer
//
// Overlays one scaled sprite on a background pixel stream. The sprite's
// top-left position is double-buffered, so a move only takes effect at a frame
// boundary and never tears mid-frame.
// Each sprite pixel covers 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels.
//
// Pipeline (2 cycles from DrawX/DrawY/blank/bg_* to red/green/blue/sprite_hit):
//   stage 0 : box test + ROM address (combinational into the synchronous ROM)
//   stage 1 : ROM read; in_box, blank and bg_* registered alongside it
//   stage 2 : colour select, registered outputs
//
// Optional feature macro: SPRITE_HIT_COUNT_EN
//   defined   -> counts opaque output pixels per frame and reports the previous
//                frame's total on hit_pixels (16-bit, saturating)
//   undefined -> no counter; hit_pixels is tied to 0
//
// Ports
//   vga_clk                      pixel clock, rising edge
//   reset_n                      synchronous active-low reset
//   DrawX, DrawY                 current pixel coordinate
//   blank                        1 = active display
//   pos_x, pos_y, pos_wr         requested sprite position + load strobe
//   bg_red/green/blue            background colour for DrawX/DrawY
//   rom_address / rom_q          external sprite ROM (1-cycle read latency)
//   pal_index / pal_red/green/blue  external combinational palette
//   red, green, blue             registered output colour
//   sprite_hit                   registered, 1 for an opaque sprite pixel
//   hit_pixels                   opaque-pixel count of the previous frame
// ---------------------------------------------------------------------------
module sprite_layer_renderer #(
    parameter int SPR_W           = 11,
    parameter int SPR_H           = 22,
    parameter int SCALE_LOG2      = 2,
    parameter int ADDR_W          = 8,
    parameter int IDX_W           = 4,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              pos_wr,
    input  logic [3:0]        bg_red,
    input  logic [3:0]        bg_green,
    input  logic [3:0]        bg_blue,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              sprite_hit,
    output logic [15:0]       hit_pixels
);

    localparam logic [10:0] BOX_W = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0] BOX_H = 11'(SPR_H << SCALE_LOG2);
    localparam logic [IDX_W-1:0] TRANSP = IDX_W'(TRANSPARENT_IDX);

    // ------------------------------------------------------------------
    // Position double buffer
    // ------------------------------------------------------------------
    logic [9:0] act_x_q, act_x_d, act_y_q, act_y_d;
    logic [9:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic       pend_flag_q, pend_flag_d;
    logic       frame_start;

    assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

    always_comb begin
        act_x_d     = act_x_q;
        act_y_d     = act_y_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        pend_flag_d = pend_flag_q;
        if (pos_wr) begin
            pend_x_d    = pos_x;
            pend_y_d    = pos_y;
            pend_flag_d = 1'b1;
        end
        if (frame_start) begin
            if (pos_wr) begin
                act_x_d     = pos_x;
                act_y_d     = pos_y;
                pend_flag_d = 1'b0;
            end else if (pend_flag_q) begin
                act_x_d     = pend_x_q;
                act_y_d     = pend_y_q;
                pend_flag_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: box test and ROM address.
    // act_*_d is the position that governs the current frame; using it here
    // means pixel (0,0) of a new frame already sees the newly loaded position.
    // ------------------------------------------------------------------
    logic [10:0]       diff_x, diff_y;
    logic [9:0]        spr_col, spr_row;
    logic              in_box;
    logic [ADDR_W-1:0] rom_addr_c;

    always_comb begin
        diff_x  = {1'b0, DrawX} - {1'b0, act_x_d};
        diff_y  = {1'b0, DrawY} - {1'b0, act_y_d};
        spr_col = diff_x[9:0] >> SCALE_LOG2;
        spr_row = diff_y[9:0] >> SCALE_LOG2;
        // Bit 10 is the borrow: pixel left of / above the sprite. The
        // on-screen guard clips the parts past x=639 / y=479 so the sprite
        // never leaks into the blanking interval.
        in_box  = !diff_x[10] && !diff_y[10] &&
                  (diff_x < BOX_W) && (diff_y < BOX_H) &&
                  (DrawX < 10'd640) && (DrawY < 10'd480);
        // Constant multiply only; the scale is a shift.
        rom_addr_c = '0;
        if (in_box)
            rom_addr_c = ADDR_W'(32'(spr_row) * SPR_W + 32'(spr_col));
    end

    assign rom_address = rom_addr_c;
    assign pal_index   = rom_q;

    // ------------------------------------------------------------------
    // Stage 1 / stage 2 registers
    // ------------------------------------------------------------------
    logic       in_box_d1_q, in_box_d1_d;
    logic       blank_d1_q,  blank_d1_d;
    logic [3:0] bg_r_d1_q, bg_r_d1_d, bg_g_d1_q, bg_g_d1_d, bg_b_d1_q, bg_b_d1_d;
    logic [3:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic       hit_q, hit_d;

    always_comb begin
        in_box_d1_d = in_box;
        blank_d1_d  = blank;
        bg_r_d1_d   = bg_red;
        bg_g_d1_d   = bg_green;
        bg_b_d1_d   = bg_blue;

        red_d   = bg_r_d1_q;
        green_d = bg_g_d1_q;
        blue_d  = bg_b_d1_q;
        hit_d   = 1'b0;
        if (!blank_d1_q) begin
            red_d   = 4'h0;
            green_d = 4'h0;
            blue_d  = 4'h0;
        end else if (in_box_d1_q && (rom_q != TRANSP)) begin
            red_d   = pal_red;
            green_d = pal_green;
            blue_d  = pal_blue;
            hit_d   = 1'b1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            act_x_q     <= '0;
            act_y_q     <= '0;
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            pend_flag_q <= 1'b0;
            in_box_d1_q <= 1'b0;
            blank_d1_q  <= 1'b0;
            bg_r_d1_q   <= '0;
            bg_g_d1_q   <= '0;
            bg_b_d1_q   <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            hit_q       <= 1'b0;
        end else begin
            act_x_q     <= act_x_d;
            act_y_q     <= act_y_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            pend_flag_q <= pend_flag_d;
            in_box_d1_q <= in_box_d1_d;
            blank_d1_q  <= blank_d1_d;
            bg_r_d1_q   <= bg_r_d1_d;
            bg_g_d1_q   <= bg_g_d1_d;
            bg_b_d1_q   <= bg_b_d1_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            hit_q       <= hit_d;
        end
    end

    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign sprite_hit = hit_q;

    // ------------------------------------------------------------------
    // Optional per-frame opaque pixel counter
    // ------------------------------------------------------------------
`ifdef SPRITE_HIT_COUNT_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, hit_pix_q, hit_pix_d;
    logic [15:0] hit_cnt_inc;

    always_comb begin
        // Saturating increment of the running count by this cycle's hit.
        hit_cnt_inc = hit_cnt_q;
        if (hit_q && (hit_cnt_q != 16'hFFFF))
            hit_cnt_inc = hit_cnt_q + 16'd1;
        hit_cnt_d = hit_cnt_inc;
        hit_pix_d = hit_pix_q;
        // The output hit seen during the boundary cycle belongs to a pixel
        // from the previous frame (2-cycle lag), so it is folded into the
        // reported total rather than the new count.
        if (frame_start) begin
            hit_pix_d = hit_cnt_inc;
            hit_cnt_d = '0;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hit_cnt_q <= '0;
            hit_pix_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
            hit_pix_q <= hit_pix_d;
        end
    end

    assign hit_pixels = hit_pix_q;
`else
    assign hit_pixels = '0;
`endif

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Directed bench for sprite_layer_renderer with default parameters
// (11x22 sprite, x4 scale -> 44x88 screen box).
// ROM model: synchronous, data = addr[3:0] | 1 (always opaque) or 0 (transparent).
// Palette model: red = idx, green = ~idx, blue = idx ^ 5.
module tb_sprite_layer_renderer;

    logic       vga_clk;
    logic       reset_n;
    logic [9:0] DrawX, DrawY;
    logic       blank;
    logic [9:0] pos_x, pos_y;
    logic       pos_wr;
    logic [3:0] bg_red, bg_green, bg_blue;
    logic [7:0] rom_address;
    logic [3:0] rom_q;
    logic [3:0] pal_index;
    logic [3:0] pal_red, pal_green, pal_blue;
    logic [3:0] red, green, blue;
    logic       sprite_hit;
    logic [15:0] hit_pixels;

    logic rom_transparent;
    int   n_chk;
    int   n_err;

    sprite_layer_renderer dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_wr     (pos_wr),
        .bg_red     (bg_red),
        .bg_green   (bg_green),
        .bg_blue    (bg_blue),
        .rom_address(rom_address),
        .rom_q      (rom_q),
        .pal_index  (pal_index),
        .pal_red    (pal_red),
        .pal_green  (pal_green),
        .pal_blue   (pal_blue),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .sprite_hit (sprite_hit),
        .hit_pixels (hit_pixels)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk)
        rom_q <= rom_transparent ? 4'h0 : (rom_address[3:0] | 4'h1);

    assign pal_red   = pal_index;
    assign pal_green = ~pal_index;
    assign pal_blue  = pal_index ^ 4'h5;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        #1;
    endtask

    task automatic bg(input logic [3:0] r, input logic [3:0] g, input logic [3:0] bl);
        bg_red = r; bg_green = g; bg_blue = bl;
    endtask

    // Apply a pixel, wait the 2-cycle latency, check colour and hit.
    task automatic px_chk(input string tag, input int x, input int y, input logic b,
                          input logic [3:0] er, input logic [3:0] eg,
                          input logic [3:0] eb, input logic eh);
        pix(x, y, b);
        tick();
        tick();
        chk({tag, "_r"}, 32'(red), 32'(er));
        chk({tag, "_g"}, 32'(green), 32'(eg));
        chk({tag, "_b"}, 32'(blue), 32'(eb));
        chk({tag, "_hit"}, 32'(sprite_hit), 32'(eh));
    endtask

    task automatic boundary(input logic wr, input int px, input int py);
        pos_x = 10'(px); pos_y = 10'(py); pos_wr = wr;
        pix(0, 0, 1'b1);
        tick();
        pos_wr = 1'b0;
    endtask

    task automatic mid_wr(input int px, input int py);
        pos_x = 10'(px); pos_y = 10'(py); pos_wr = 1'b1;
        pix(10, 10, 1'b1);
        tick();
        pos_wr = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rom_transparent = 1'b0;
        reset_n = 1'b0;
        pos_x = '0; pos_y = '0; pos_wr = 1'b0;
        bg(4'h3, 4'h4, 4'h5);
        pix(0, 0, 1'b1);
        tick(); tick(); tick();
        chk("rst_r", 32'(red), 0);
        chk("rst_g", 32'(green), 0);
        chk("rst_b", 32'(blue), 0);
        chk("rst_hit", 32'(sprite_hit), 0);
        chk("rst_hitpix", 32'(hit_pixels), 0);
        reset_n = 1'b1;

        // Position 0/0: (5,9) -> row 2, col 1 -> 23; idx 7
        pix(5, 9, 1'b1);
        chk("addr23", 32'(rom_address), 23);
        tick();
        chk("pal_idx", 32'(pal_index), 7);
        tick();
        chk("p23_r", 32'(red), 4'h7);
        chk("p23_g", 32'(green), 4'h8);
        chk("p23_b", 32'(blue), 4'h2);
        chk("p23_hit", 32'(sprite_hit), 1);

        // Exact 2-cycle latency: opaque pixel followed by an outside pixel
        pix(5, 9, 1'b1);
        tick();
        pix(100, 100, 1'b1);
        tick();
        chk("lat_a_r", 32'(red), 4'h7);
        chk("lat_a_hit", 32'(sprite_hit), 1);
        tick();
        chk("lat_b_r", 32'(red), 4'h3);
        chk("lat_b_hit", 32'(sprite_hit), 0);

        // Transparent index inside the box shows background
        rom_transparent = 1'b1;
        bg(4'hA, 4'hA, 4'hA);
        px_chk("transp", 5, 9, 1'b1, 4'hA, 4'hA, 4'hA, 1'b0);
        rom_transparent = 1'b0;

        // Blanking inside an opaque box
        px_chk("blank", 5, 9, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        bg(4'h3, 4'h4, 4'h5);

        // Mid-frame move to (100,50): no effect until the next boundary
        mid_wr(100, 50);
        pix(5, 9, 1'b1);
        chk("pend_old_addr", 32'(rom_address), 23);
        px_chk("pend_old", 5, 9, 1'b1, 4'h7, 4'h8, 4'h2, 1'b1);
        boundary(1'b0, 0, 0);
        px_chk("mv_x99", 99, 50, 1'b1, 4'h3, 4'h4, 4'h5, 1'b0);
        pix(100, 50, 1'b1);
        chk("mv_x100_addr", 32'(rom_address), 0);
        px_chk("mv_x100", 100, 50, 1'b1, 4'h1, 4'hE, 4'h4, 1'b1);
        pix(104, 54, 1'b1);
        chk("mv_addr12", 32'(rom_address), 12);
        px_chk("mv_old_spot", 5, 9, 1'b1, 4'h3, 4'h4, 4'h5, 1'b0);

        // Pending write overridden by a write on the boundary; pend clears
        mid_wr(300, 300);
        boundary(1'b1, 620, 0);
        px_chk("edge_620", 620, 1, 1'b1, 4'h1, 4'hE, 4'h4, 1'b1);
        boundary(1'b0, 0, 0);
        pix(639, 2, 1'b1);
        chk("edge_addr4", 32'(rom_address), 4);
        px_chk("edge_639", 639, 2, 1'b1, 4'h5, 4'hA, 4'h0, 1'b1);
        px_chk("edge_619", 619, 2, 1'b1, 4'h3, 4'h4, 4'h5, 1'b0);
        px_chk("edge_x0", 0, 2, 1'b1, 4'h3, 4'h4, 4'h5, 1'b0);
        px_chk("edge_stale300", 300, 300, 1'b1, 4'h3, 4'h4, 4'h5, 1'b0);

        // Off-screen position: nothing visible
        boundary(1'b1, 700, 0);
        px_chk("off_639", 639, 5, 1'b1, 4'h3, 4'h4, 4'h5, 1'b0);

        // Reset mid-frame drops the pending position and clears outputs
        mid_wr(200, 200);
        reset_n = 1'b0;
        pix(5, 9, 1'b1);
        tick();
        chk("mrst_hit", 32'(sprite_hit), 0);
        chk("mrst_r", 32'(red), 0);
        reset_n = 1'b1;
        boundary(1'b0, 0, 0);
        pix(5, 9, 1'b1);
        chk("mrst_addr23", 32'(rom_address), 23);

        // Full opaque 44x88 sprite at 0/0, then boundary reports the count
        boundary(1'b0, 0, 0);
        for (int y = 0; y < 88; y++)
            for (int x = 0; x < 44; x++)
                if (x != 0 || y != 0) begin
                    pix(x, y, 1'b1);
                    tick();
                end
        for (int i = 0; i < 3; i++) begin
            pix(600, 400, 1'b1);
            tick();
        end
        boundary(1'b0, 0, 0);
`ifdef SPRITE_HIT_COUNT_EN
        chk("hit_pixels", 32'(hit_pixels), 3872);
`else
        chk("hit_pixels", 32'(hit_pixels), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
